lcd_nibble_writer: RTL and testbench

- HD44780 4-bit write engine driving the starter-board character LCD pins (LCD_E, LCD_RS, LCD_RW, SF_DATA).
- Runs the power-on initialisation sequence autonomously.
- Then accepts one byte at a time (command or character) from MiniAlu's LCD instruction path over a valid/ready handshake, and serialises each byte as two timed nibble strobes.
- Replaces the free-running character-buffer display path with a request-driven one.

---
 rtl/lcd_nibble_writer_if.sv | 13 +
 rtl/lcd_nibble_writer.sv | 228 ++++++++++++++++++++++
 tb/tb_lcd_nibble_writer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_nibble_writer_if.sv
// Request channel between the LCD instruction path and the nibble writer.
// valid/ready: a byte transfers on a rising edge where iValid && oReady; iRS/iData must be stable on that edge.
interface lcd_nibble_writer_if;
  logic       iValid;
  logic       iRS;
  logic [7:0] iData;
  logic       oReady;
  logic       oInitDone;
  logic [3:0] dbg_state;

  modport master (output iValid, iRS, iData, input oReady, oInitDone, dbg_state);
  modport slave  (input iValid, iRS, iData, output oReady, oInitDone, dbg_state);
endinterface

// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit write engine: runs the power-on init sequence, then serialises
// one requested byte at a time into two timed LCD_E nibble strobes.
module lcd_nibble_writer #(
   parameter int T_POWERON = 750000,
   parameter int T_4100US  = 205000,
   parameter int T_100US   = 5000,
   parameter int T_40US    = 2000,
   parameter int T_1640US  = 82000,
   parameter int T_SETUP   = 2,
   parameter int T_EPULSE  = 12,
   parameter int T_HOLD    = 2,
   parameter int T_NIBGAP  = 50,
   parameter int CNT_W     = 20
) (
   input  logic       Clock,
   input  logic       Reset,
   lcd_nibble_writer_if.slave bus,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [3:0] SF_DATA
);

   localparam logic [3:0] S_POWER_WAIT = 4'd0;
   localparam logic [3:0] S_INIT_NIB   = 4'd1;
   localparam logic [3:0] S_INIT_WAIT  = 4'd2;
   localparam logic [3:0] S_CFG        = 4'd3;
   localparam logic [3:0] S_IDLE       = 4'd4;
   localparam logic [3:0] S_NIB_SETUP  = 4'd5;
   localparam logic [3:0] S_NIB_E      = 4'd6;
   localparam logic [3:0] S_NIB_HOLD   = 4'd7;
   localparam logic [3:0] S_NIB_GAP    = 4'd8;
   localparam logic [3:0] S_BYTE_WAIT  = 4'd9;

   localparam logic [CNT_W-1:0] C_POWER = CNT_W'(T_POWERON - 1);
   localparam logic [CNT_W-1:0] C_4100  = CNT_W'(T_4100US - 1);
   localparam logic [CNT_W-1:0] C_100   = CNT_W'(T_100US - 1);
   localparam logic [CNT_W-1:0] C_40    = CNT_W'(T_40US - 1);
   localparam logic [CNT_W-1:0] C_1640  = CNT_W'(T_1640US - 1);
   localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] C_E     = CNT_W'(T_EPULSE - 1);
   localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] C_GAP   = CNT_W'(T_NIBGAP - 1);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       byte_q, byte_d;
   logic             rs_byte_q, rs_byte_d;
   logic             phase_q, phase_d;
   logic             init_mode_q, init_mode_d;
   logic             cfg_mode_q, cfg_mode_d;
   logic [1:0]       init_idx_q, init_idx_d;
   logic [1:0]       cfg_idx_q, cfg_idx_d;
   logic             ready_q, ready_d;
   logic             init_done_q, init_done_d;
   logic             e_q, e_d;
   logic             rs_q, rs_d;
   logic [3:0]       sf_q, sf_d;

   logic             accept;
   logic             cnt_zero;
   logic             long_wait;
   logic [3:0]       cur_nib;
   logic             cur_rs;
   logic [7:0]       cfg_byte;
   logic [CNT_W-1:0] init_wait;

   always_comb begin
      cur_nib   = init_mode_q ? ((init_idx_q == 2'd3) ? 4'h2 : 4'h3)
                              : (phase_q ? byte_q[3:0] : byte_q[7:4]);
      cur_rs    = init_mode_q ? 1'b0 : rs_byte_q;
      long_wait = !rs_byte_q && ((byte_q == 8'h01) || (byte_q == 8'h02));
      unique case (cfg_idx_q)
         2'd0:    cfg_byte = 8'h28;
         2'd1:    cfg_byte = 8'h06;
         2'd2:    cfg_byte = 8'h0C;
         default: cfg_byte = 8'h01;
      endcase
      unique case (init_idx_q)
         2'd0:    init_wait = C_4100;
         2'd1:    init_wait = C_100;
         default: init_wait = C_40;
      endcase
   end

   // Pin outputs are registered one cycle behind the FSM, so every pin change
   // lands on the edge after the state that asks for it.
   always_comb begin
      accept      = bus.iValid && ready_q;
      cnt_zero    = (cnt_q == '0);
      ready_d     = (state_q == S_IDLE) && !accept;
      init_done_d = init_done_q || ready_d;
      e_d         = (state_q == S_NIB_E);
      sf_d        = (state_q == S_NIB_SETUP) ? cur_nib : sf_q;
      rs_d        = (state_q == S_NIB_SETUP) ? cur_rs : rs_q;
      state_d     = state_q;
      cnt_d       = cnt_zero ? cnt_q : cnt_q - 1'b1;
      byte_d      = byte_q;
      rs_byte_d   = rs_byte_q;
      phase_d     = phase_q;
      init_mode_d = init_mode_q;
      cfg_mode_d  = cfg_mode_q;
      init_idx_d  = init_idx_q;
      cfg_idx_d   = cfg_idx_q;

      unique case (state_q)
         S_POWER_WAIT: begin
            // Counts up from the cleared value so reset alone starts the power-on wait.
            if (cnt_q == C_POWER) begin
               state_d = S_INIT_NIB;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_INIT_NIB: begin
            init_mode_d = 1'b1;
            state_d     = S_NIB_SETUP;
            cnt_d       = C_SETUP;
         end
         S_NIB_SETUP: if (cnt_zero) begin
            state_d = S_NIB_E;
            cnt_d   = C_E;
         end
         S_NIB_E: if (cnt_zero) begin
            state_d = S_NIB_HOLD;
            cnt_d   = C_HOLD;
         end
         S_NIB_HOLD: if (cnt_zero) begin
            if (init_mode_q) begin
               state_d = S_INIT_WAIT;
               cnt_d   = init_wait;
            end else if (!phase_q) begin
               state_d = S_NIB_GAP;
               cnt_d   = C_GAP;
            end else begin
               state_d = S_BYTE_WAIT;
               cnt_d   = long_wait ? C_1640 : C_40;
            end
         end
         S_NIB_GAP: if (cnt_zero) begin
            phase_d = 1'b1;
            state_d = S_NIB_SETUP;
            cnt_d   = C_SETUP;
         end
         S_INIT_WAIT: if (cnt_zero) begin
            init_mode_d = 1'b0;
            if (init_idx_q == 2'd3) begin
               state_d = S_CFG;
            end else begin
               init_idx_d = init_idx_q + 2'd1;
               state_d    = S_INIT_NIB;
            end
         end
         S_CFG: begin
            byte_d     = cfg_byte;
            rs_byte_d  = 1'b0;
            phase_d    = 1'b0;
            cfg_mode_d = 1'b1;
            state_d    = S_NIB_SETUP;
            cnt_d      = C_SETUP;
         end
         S_BYTE_WAIT: if (cnt_zero) begin
            if (cfg_mode_q && (cfg_idx_q != 2'd3)) begin
               cfg_idx_d = cfg_idx_q + 2'd1;
               state_d   = S_CFG;
            end else begin
               cfg_mode_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         S_IDLE: if (accept) begin
            byte_d    = bus.iData;
            rs_byte_d = bus.iRS;
            phase_d   = 1'b0;
            state_d   = S_NIB_SETUP;
            cnt_d     = C_SETUP;
         end
         default: begin
            state_d = S_POWER_WAIT;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= S_POWER_WAIT;
         cnt_q       <= '0;
         byte_q      <= '0;
         rs_byte_q   <= 1'b0;
         phase_q     <= 1'b0;
         init_mode_q <= 1'b0;
         cfg_mode_q  <= 1'b0;
         init_idx_q  <= '0;
         cfg_idx_q   <= '0;
         ready_q     <= 1'b0;
         init_done_q <= 1'b0;
         e_q         <= 1'b0;
         rs_q        <= 1'b0;
         sf_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         byte_q      <= byte_d;
         rs_byte_q   <= rs_byte_d;
         phase_q     <= phase_d;
         init_mode_q <= init_mode_d;
         cfg_mode_q  <= cfg_mode_d;
         init_idx_q  <= init_idx_d;
         cfg_idx_q   <= cfg_idx_d;
         ready_q     <= ready_d;
         init_done_q <= init_done_d;
         e_q         <= e_d;
         rs_q        <= rs_d;
         sf_q        <= sf_d;
      end
   end

   assign bus.oReady    = ready_q;
   assign bus.oInitDone = init_done_q;
   assign bus.dbg_state = state_q;
   assign LCD_E         = e_q;
   assign LCD_RS        = rs_q;
   assign LCD_RW        = 1'b0;
   assign SF_DATA       = sf_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Bench for lcd_nibble_writer with shortened timing: strobe scoreboard,
// accept-to-ready latency checks and pin timing checks.
module tb_lcd_nibble_writer;

   localparam int T_SETUP  = 2;
   localparam int T_EPULSE = 3;
   localparam int T_HOLD   = 1;
   localparam int T_NIBGAP = 2;
   localparam int T_40US   = 4;
   localparam int T_1640US = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       lcd_e, lcd_rs, lcd_rw;
   logic [3:0] sf_data;

   lcd_nibble_writer_if bus ();

   lcd_nibble_writer #(
      .T_POWERON(20), .T_4100US(10), .T_100US(6), .T_40US(T_40US),
      .T_1640US(T_1640US), .T_SETUP(T_SETUP), .T_EPULSE(T_EPULSE),
      .T_HOLD(T_HOLD), .T_NIBGAP(T_NIBGAP), .CNT_W(20)
   ) dut (
      .Clock(clk), .Reset(rst_n), .bus(bus.slave),
      .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .SF_DATA(sf_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [4:0] exp_q[$];
   int         lat_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_byte(input logic rs, input logic [7:0] d, input bit with_lat);
      int tw;
      exp_q.push_back({rs, d[7:4]});
      exp_q.push_back({rs, d[3:0]});
      tw = (!rs && (d == 8'h01 || d == 8'h02)) ? T_1640US : T_40US;
      if (with_lat) lat_q.push_back(2 * (T_SETUP + T_EPULSE + T_HOLD) + T_NIBGAP + tw + 1);
   endtask

   task automatic push_init();
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h02);
      push_byte(1'b0, 8'h28, 1'b0);
      push_byte(1'b0, 8'h06, 1'b0);
      push_byte(1'b0, 8'h0C, 1'b0);
      push_byte(1'b0, 8'h01, 1'b0);
   endtask

   task automatic wait_ready(input int limit, input string name);
      int n = 0;
      while (!bus.oReady && n < limit) begin
         @(posedge clk); #2;
         n++;
      end
      if (!bus.oReady) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=0 required=1", name);
      end
   endtask

   task automatic send_byte(input logic rs, input logic [7:0] d);
      wait_ready(200, "send_wait");
      push_byte(rs, d, 1'b1);
      bus.iValid = 1'b1;
      bus.iRS    = rs;
      bus.iData  = d;
      @(posedge clk); #2;
      bus.iValid = 1'b0;
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   logic       prev_e, prev_rs, prev_ready, prev_done, acc_pending;
   logic [3:0] prev_data;
   int         stable, e_len, acc_cyc, lat_exp;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_e = 0; prev_rs = 0; prev_data = 0; prev_ready = 0; prev_done = 0;
         acc_pending = 0; stable = 0; e_len = 0;
      end else begin
         check("lcd_rw", {31'd0, lcd_rw}, 32'd0);
         if (lcd_e != prev_e)
            check("e_same_edge_data", {31'd0, (sf_data != prev_data) || (lcd_rs != prev_rs)}, 32'd0);
         stable = (sf_data == prev_data && lcd_rs == prev_rs) ? stable + 1 : 0;
         if (lcd_e && !prev_e) begin
            check("setup_stable", {31'd0, stable >= T_SETUP}, 32'd1);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL strobe unexpected actual=%0h required=none", {lcd_rs, sf_data});
            end else begin
               check("strobe", {27'd0, lcd_rs, sf_data}, {27'd0, exp_q.pop_front()});
            end
         end
         e_len = lcd_e ? e_len + 1 : e_len;
         if (!lcd_e && prev_e) begin
            check("e_width", e_len, T_EPULSE);
            e_len = 0;
         end
         if (bus.oInitDone && !prev_done) check("init_done_with_ready", {31'd0, bus.oReady}, 32'd1);
         if (bus.oReady && !prev_ready && acc_pending) begin
            acc_pending = 0;
            if (lat_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL latency unexpected actual=%0d required=none", cyc - acc_cyc);
            end else begin
               lat_exp = lat_q.pop_front();
               check("ready_latency", cyc - acc_cyc, lat_exp);
            end
         end
         if (bus.iValid && bus.oReady) begin
            acc_pending = 1;
            acc_cyc     = cyc + 1;
         end
         prev_e = lcd_e; prev_rs = lcd_rs; prev_data = sf_data;
         prev_ready = bus.oReady; prev_done = bus.oInitDone;
      end
   end

   initial begin
      int n, pulses;
      logic pe;
      bus.iValid = 1'b0;
      bus.iRS    = 1'b0;
      bus.iData  = 8'h00;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_ready", {31'd0, bus.oReady}, 32'd0);
      check("rst_init_done", {31'd0, bus.oInitDone}, 32'd0);
      check("rst_e", {31'd0, lcd_e}, 32'd0);
      check("rst_rs", {31'd0, lcd_rs}, 32'd0);
      check("rst_data", {28'd0, sf_data}, 32'd0);
      rst_n = 1'b1;
      push_init();

      // Init sequence with no requests pending.
      wait_ready(500, "init_wait");
      check("init_done", {31'd0, bus.oInitDone}, 32'd1);

      // Character, clear command (long wait), and 0x01 as data (short wait).
      send_byte(1'b1, 8'h41);
      send_byte(1'b0, 8'h01);
      send_byte(1'b1, 8'h01);
      send_byte(1'b0, 8'h02);

      // Back-to-back with iValid held, then a pulse while busy that must be ignored.
      wait_ready(200, "b2b_wait");
      push_byte(1'b1, 8'h48, 1'b1);
      bus.iValid = 1'b1; bus.iRS = 1'b1; bus.iData = 8'h48;
      @(posedge clk); #2;
      push_byte(1'b1, 8'h49, 1'b1);
      bus.iData = 8'h49;
      repeat (3) @(posedge clk);
      #2;
      wait_ready(200, "b2b_second");
      @(posedge clk); #2;
      check("b2b_first_edge_accept", {31'd0, bus.oReady}, 32'd0);
      bus.iValid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      bus.iValid = 1'b1; bus.iData = 8'h77;
      @(posedge clk); #2;
      bus.iValid = 1'b0;

      // Reset while LCD_E is high on the low nibble.
      send_byte(1'b1, 8'h41);
      n = 0; pulses = 0; pe = 0;
      while (pulses < 2 && n < 100) begin
         @(negedge clk);
         if (lcd_e && !pe) pulses++;
         pe = lcd_e;
         n++;
      end
      check("mid_strobe_reached", pulses, 2);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_e", {31'd0, lcd_e}, 32'd0);
      check("async_rst_data", {28'd0, sf_data}, 32'd0);
      check("async_rst_rs", {31'd0, lcd_rs}, 32'd0);
      check("async_rst_ready", {31'd0, bus.oReady}, 32'd0);
      check("async_rst_init_done", {31'd0, bus.oInitDone}, 32'd0);
      check("strobes_before_rst", exp_q.size(), 0);
      lat_q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Request held from POWER_WAIT through CFG; only taken once init is done.
      push_init();
      push_byte(1'b1, 8'h55, 1'b1);
      bus.iValid = 1'b1; bus.iRS = 1'b1; bus.iData = 8'h55;
      wait_ready(500, "replay_init");
      check("replay_init_done", {31'd0, bus.oInitDone}, 32'd1);
      @(posedge clk); #2;
      bus.iValid = 1'b0;
      wait_ready(200, "final_wait");
      repeat (3) @(posedge clk);
      #2;
      check("exp_queue_drained", exp_q.size(), 0);
      check("lat_queue_drained", lat_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
